// File: rtl/lb_pkg.sv
// Types shared by the line-buffer write- and read-side controllers.
package lb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DRAIN = 2'd2
  } lbw_state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous clear (priority) and increment enable.
// Registered output, no handshake; clr wins over inc in the same cycle.
module mod_counter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == W'(N - 1)) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lb_write_controller.sv
// Circular line-buffer write controller: zero-latency write address from accepted pixels.
// inReady drops while every line slot holds an unreleased line; it never looks at inValid.
module lb_write_controller
  import lb_pkg::*;
#(
  parameter int LINES     = 4,
  parameter int LINE_BITS = $clog2(LINES),
  parameter int WIDTH     = 1920,
  parameter int AW        = $clog2(WIDTH),
  parameter int HEIGHT    = 1080,
  parameter int HW        = $clog2(HEIGHT),
  parameter int SH        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frameStart,
  input  logic                 inValid,
  output logic                 inReady,
  output logic                 wrEn,
  output logic [LINE_BITS-1:0] wrLine,
  output logic [AW-1:0]        wrCol,
  output logic [HW-1:0]        wrRow,
  input  logic                 lineRelease,
  output logic [LINE_BITS-1:0] rdBase,
  output logic [LINE_BITS:0]   linesAvail,
  output logic                 stencilReady,
  output logic                 rowWritten,
  output logic                 frameDone
);

  lbw_state_t state;
  logic       start;
  logic       accept;
  logic       rowDone;
  logic       relOk;

  assign start        = (state == IDLE) && frameStart;
  assign inReady      = (state == WRITE) && (linesAvail < (LINE_BITS + 1)'(LINES));
  assign accept       = inValid && inReady;
  assign wrEn         = accept;
  assign rowDone      = accept && (wrCol == AW'(WIDTH - 1));
  assign relOk        = lineRelease && (linesAvail != '0);
  assign stencilReady = linesAvail >= (LINE_BITS + 1)'(SH);

  mod_counter #(.N(WIDTH), .W(AW)) uColCnt (
    .clk (clk), .rst (rst), .clr (start), .inc (accept), .cnt (wrCol)
  );

  mod_counter #(.N(LINES), .W(LINE_BITS)) uWrLineCnt (
    .clk (clk), .rst (rst), .clr (start), .inc (rowDone), .cnt (wrLine)
  );

  mod_counter #(.N(LINES), .W(LINE_BITS)) uRdBaseCnt (
    .clk (clk), .rst (rst), .clr (start), .inc (relOk), .cnt (rdBase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wrRow      <= '0;
      linesAvail <= '0;
      rowWritten <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      rowWritten <= rowDone;
      frameDone  <= 1'b0;

      // Simultaneous completion and release cancel, keeping wrLine == rdBase + linesAvail.
      if (start) begin
        linesAvail <= '0;
      end else if (rowDone && !relOk) begin
        linesAvail <= linesAvail + 1'b1;
      end else if (relOk && !rowDone) begin
        linesAvail <= linesAvail - 1'b1;
      end

      if (start) begin
        wrRow <= '0;
      end else if (rowDone) begin
        wrRow <= wrRow + 1'b1;
      end

      case (state)
        IDLE: begin
          if (frameStart) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (rowDone && (wrRow == HW'(HEIGHT - 1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (linesAvail == '0) begin
            state     <= IDLE;
            frameDone <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_write_controller.sv
// Randomized bench: count-based reference model checked every cycle plus a write-address scoreboard.
module tb_lb_write_controller;

  localparam int LINES  = 4;
  localparam int LB     = 2;
  localparam int WIDTH  = 8;
  localparam int AW     = 3;
  localparam int HEIGHT = 6;
  localparam int HW     = 3;
  localparam int SH     = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frameStart = 1'b0;
  logic          inValid = 1'b0;
  logic          lineRelease = 1'b0;
  logic          inReady, wrEn, stencilReady, rowWritten, frameDone;
  logic [LB-1:0] wrLine, rdBase;
  logic [AW-1:0] wrCol;
  logic [HW-1:0] wrRow;
  logic [LB:0]   linesAvail;

  lb_write_controller #(
    .LINES(LINES), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SH(SH)
  ) dut (
    .clk(clk), .rst(rst), .frameStart(frameStart), .inValid(inValid), .inReady(inReady),
    .wrEn(wrEn), .wrLine(wrLine), .wrCol(wrCol), .wrRow(wrRow), .lineRelease(lineRelease),
    .rdBase(rdBase), .linesAvail(linesAvail), .stencilReady(stencilReady),
    .rowWritten(rowWritten), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int line;
    int col;
    int row;
  } wr_t;

  wr_t q[$];
  int  nCmp = 0;
  int  nBad = 0;

  // Reference model: phase 0 idle, 1 writing, 2 draining; everything else is plain counts.
  int  phase = 0, rowsDone = 0, released = 0, accepts = 0;
  bit  rwExp = 0, fdExp = 0;
  int  accCount = 0, rwCount = 0, fdCount = 0, srAt = -1;

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin : model
    int  avail;
    bit  acc, rowFin, rel;
    @(posedge clk or posedge rst);
    if (rst) begin
      phase = 0; rowsDone = 0; released = 0; accepts = 0;
      rwExp = 0; fdExp = 0;
      q.delete();
    end else begin
      avail  = rowsDone - released;
      acc    = inValid && (phase == 1) && (avail < LINES);
      rowFin = acc && ((accepts % WIDTH) == WIDTH - 1);
      rel    = lineRelease && (avail > 0);
      rwExp  = 0;
      fdExp  = 0;
      if (phase == 0 && frameStart) begin
        phase = 1; rowsDone = 0; released = 0; accepts = 0;
      end else begin
        if (acc) accepts++;
        if (rowFin) begin rowsDone++; rwExp = 1; end
        if (rel) released++;
        if (phase == 1 && rowFin && accepts == WIDTH * HEIGHT) phase = 2;
        else if (phase == 2 && avail == 0) begin phase = 0; fdExp = 1; end
      end
    end
  end

  initial forever begin : monitor
    int  avail;
    bit  expRdy;
    wr_t e;
    @(negedge clk);
    if (!rst) begin
      avail  = rowsDone - released;
      expRdy = (phase == 1) && (avail < LINES);
      chk("inReady", int'(inReady), int'(expRdy));
      chk("wrEn", int'(wrEn), int'(inValid && expRdy));
      chk("linesAvail", int'(linesAvail), avail);
      chk("rdBase", int'(rdBase), released % LINES);
      chk("wrLineModel", int'(wrLine), rowsDone % LINES);
      chk("wrColModel", int'(wrCol), accepts % WIDTH);
      chk("stencilReady", int'(stencilReady), int'(avail >= SH));
      chk("rowWritten", int'(rowWritten), int'(rwExp));
      chk("frameDone", int'(frameDone), int'(fdExp));
      if (stencilReady && srAt < 0) srAt = accCount;
      if (rowWritten) rwCount++;
      if (frameDone) fdCount++;
      if (wrEn) begin
        accCount++;
        if (q.size() == 0) begin
          chk("sbUnexpectedWrite", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sbLine", int'(wrLine), e.line);
          chk("sbCol", int'(wrCol), e.col);
          chk("sbRow", int'(wrRow), e.row);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startFrame();
    tick();
    frameStart = 1'b1;
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        q.push_back('{r % LINES, c, r});
    tick();
    frameStart = 1'b0;
  endtask

  task automatic doReset();
    tick();
    inValid = 1'b0; lineRelease = 1'b0; frameStart = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    accCount = 0; rwCount = 0; fdCount = 0; srAt = -1;
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_inReady"}, int'(inReady), 0);
    chk({tag, "_wrEn"}, int'(wrEn), 0);
    chk({tag, "_wrLine"}, int'(wrLine), 0);
    chk({tag, "_wrCol"}, int'(wrCol), 0);
    chk({tag, "_wrRow"}, int'(wrRow), 0);
    chk({tag, "_rdBase"}, int'(rdBase), 0);
    chk({tag, "_linesAvail"}, int'(linesAvail), 0);
    chk({tag, "_stencil"}, int'(stencilReady), 0);
    chk({tag, "_rowWritten"}, int'(rowWritten), 0);
    chk({tag, "_frameDone"}, int'(frameDone), 0);
  endtask

  initial begin : stim
    int n;
    #1 rst = 1'b1;
    #20;
    chkResetOutputs("reset");
    tick();
    rst = 1'b0;

    // Continuous stream, reader releases whenever a full stencil is resident.
    startFrame();
    for (n = 0; n < 300 && fdCount == 0; n++) begin
      tick();
      inValid     = 1'b1;
      lineRelease = stencilReady || (accCount >= WIDTH * HEIGHT && linesAvail != 0);
    end
    inValid = 1'b0; lineRelease = 1'b0;
    chk("s1_rowWritten", rwCount, HEIGHT);
    chk("s1_stencilRiseAcc", srAt, 3 * WIDTH);
    chk("s1_frameDone", fdCount, 1);

    // No release: the buffer fills and back-pressures.
    doReset();
    startFrame();
    inValid = 1'b1;
    repeat (60) tick();
    chk("s2_accepted", accCount, LINES * WIDTH);
    chk("s2_inReady", int'(inReady), 0);
    chk("s2_linesAvail", int'(linesAvail), LINES);
    lineRelease = 1'b1;
    tick();
    lineRelease = 1'b0;
    chk("s2_rdBase", int'(rdBase), 1);
    chk("s2_inReadyBack", int'(inReady), 1);

    // Release coincident with a row-completing accept.
    doReset();
    startFrame();
    inValid = 1'b1;
    for (n = 0; n < 100; n++) begin
      if (linesAvail == 2 && wrCol == AW'(WIDTH - 1) && inReady) break;
      tick();
    end
    chk("s3_reached", int'(n < 100), 1);
    lineRelease = 1'b1;
    tick();
    lineRelease = 1'b0; inValid = 1'b0;
    chk("s3_linesAvail", int'(linesAvail), 2);
    chk("s3_wrLine", int'(wrLine), 3);
    chk("s3_rdBase", int'(rdBase), 1);

    // Release with nothing resident is ignored.
    doReset();
    startFrame();
    lineRelease = 1'b1;
    tick();
    lineRelease = 1'b0;
    tick();
    chk("s4_rdBase", int'(rdBase), 0);
    chk("s4_linesAvail", int'(linesAvail), 0);

    // Full frame with random source and reader, then drain.
    for (n = 0; n < 2000 && accCount < WIDTH * HEIGHT; n++) begin
      tick();
      inValid     = ($urandom_range(0, 3) != 0);
      lineRelease = ($urandom_range(0, 2) == 0);
    end
    tick();
    inValid = 1'b1; lineRelease = 1'b0;
    chk("s5_accepted", accCount, WIDTH * HEIGHT);
    chk("s5_drainReady", int'(inReady), 0);
    for (n = 0; n < 50 && fdCount == 0; n++) begin
      lineRelease = (linesAvail != 0);
      tick();
    end
    lineRelease = 1'b0; inValid = 1'b0;
    repeat (3) tick();
    chk("s5_frameDonePulses", fdCount, 1);
    startFrame();
    chk("s5_restartRow", int'(wrRow), 0);
    chk("s5_restartReady", int'(inReady), 1);

    // Asynchronous reset in the middle of a row.
    inValid = 1'b1;
    for (n = 0; n < 20 && wrCol != 3'd5; n++) tick();
    chk("s6_reachedCol5", int'(wrCol), 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chkResetOutputs("midReset");
    tick();
    rst = 1'b0;
    n = accCount;
    repeat (5) tick();
    chk("s6_noAcceptIdle", accCount, n);
    startFrame();
    repeat (10) tick();
    inValid = 1'b0;
    chk("s6_restartAccepts", accCount - n, 10);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/lb_write_controller.md
# lb_write_controller

Write-side controller for the circular line buffer. It accepts a raster pixel stream with a valid/ready handshake and produces the line-buffer write address (line, column). It tracks how many complete lines are resident and not yet released by the reader, and back-pressures the source when every line slot is occupied. It sits between the input pixel source and the line-buffer RAMs, and supplies the read-side controller with the oldest resident line index and a stencil-ready indication.

## Interface
- `LINES`, 4: physical lines in the buffer.
- `LINE_BITS`, `$clog2(LINES)`: line index width.
- `WIDTH`, 1920: pixels per row.
- `AW`, `$clog2(WIDTH)`: column address width.
- `HEIGHT`, 1080: rows per frame.
- `HW`, `$clog2(HEIGHT)`: row counter width.
- `SH`, 3: stencil height, i.e. lines the reader needs resident (1..LINES).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `frameStart`, in, 1: one-cycle pulse that arms a new frame (honoured only in IDLE).
- `inValid`, in, 1: source pixel valid.
- `inReady`, out, 1: controller accepts a pixel this cycle.
- `wrEn`, out, 1: line-buffer write strobe, `inValid && inReady`.
- `wrLine`, out, LINE_BITS: line slot being written.
- `wrCol`, out, AW: column being written.
- `wrRow`, out, HW: frame row being written.
- `lineRelease`, in, 1: reader pulse meaning the oldest line is no longer needed.
- `rdBase`, out, LINE_BITS: oldest resident line slot, the reader's first line.
- `linesAvail`, out, LINE_BITS+1: complete, unreleased lines (0..LINES).
- `stencilReady`, out, 1: `linesAvail >= SH`.
- `rowWritten`, out, 1: one-cycle pulse, registered, after the last pixel of a row is accepted.
- `frameDone`, out, 1: one-cycle pulse when the frame has been fully written and drained.

## Operation
- **States:** IDLE, WRITE, DRAIN.
- **IDLE → WRITE:** on `frameStart`. Entering WRITE clears `wrCol`, `wrRow`, `wrLine`, `rdBase` and `linesAvail`.
- **`inReady`:** high only when the state is WRITE and `linesAvail < LINES`. It is combinational from registered state only and never depends on `inValid`.
- **On each accept:**
  - Increment `wrCol`.
  - At `wrCol == WIDTH-1`: set `wrCol` to 0, advance `wrLine` modulo LINES, increment `wrRow`, increment `linesAvail`, and pulse `rowWritten` next cycle.
- **Last row:** on the accept at `wrCol == WIDTH-1` and `wrRow == HEIGHT-1`, go WRITE → DRAIN.
- **DRAIN → IDLE:** when `linesAvail == 0`, with `frameDone` pulsed in the same transition.
- **`lineRelease` with `linesAvail > 0`:** decrement `linesAvail` and advance `rdBase` modulo LINES.
- **`lineRelease` with `linesAvail == 0`:** ignored, no underflow.
- **Row completion and release in the same cycle:** `linesAvail` is unchanged, `wrLine` and `rdBase` both advance.
- **Wrap invariant:** `wrLine == (rdBase + linesAvail) mod LINES` at all times.
- **`frameStart` outside IDLE:** ignored.
- **`inValid` outside WRITE:** no accept, no state change.

## Timing
- **Reset values:**
  - state IDLE, `inReady` 0, `wrEn` 0.
  - `wrLine`, `wrCol`, `wrRow`, `rdBase`, `linesAvail` all 0.
  - `stencilReady` 0, `rowWritten` 0, `frameDone` 0.
- **Reset mid-frame:** returns to IDLE immediately (asynchronous). All counters cleared, nothing further written.
- **Write path:** `wrEn`, `wrLine`, `wrCol` are valid in the accept cycle, so the RAM captures on that clock edge. Zero latency.
- **`linesAvail` and `stencilReady`:** update on the edge after the last-column accept or the release. `stencilReady` is combinational from registered `linesAvail`.
- **Back-pressure:** `inReady` drops the cycle after the accept that makes `linesAvail == LINES`. It rises the cycle after a `lineRelease` is registered.
- **`frameDone`:** asserts one cycle after `linesAvail` reaches 0 in DRAIN. The next `frameStart` is accepted the cycle after that.

## Structure
- **Shared package `lb_pkg`:** holds the `lbw_state_t` enum (IDLE, WRITE, DRAIN). The read-side controller uses the same package.
- **Sub-module `mod_counter`:** parameterised modulo-N counter with increment enable and synchronous clear. Instantiate it for `wrCol` (N = WIDTH), `wrLine` (N = LINES) and `rdBase` (N = LINES).
- `linesAvail` and the FSM stay in the top module.

## Test plan
Parameters for all scenarios: LINES=4, WIDTH=8, HEIGHT=6, SH=3.

1. **Continuous stream, reader releasing whenever `stencilReady`:**
   - `rowWritten` pulses 6 times.
   - `wrLine` sequence is 0,1,2,3,0,1.
   - `stencilReady` first rises one cycle after the 24th accept.
2. **No release:**
   - Exactly 32 pixels are accepted, then `inReady` = 0 and `linesAvail` = 4.
   - A single `lineRelease` gives `rdBase` = 1 and `inReady` = 1 one cycle later.
3. **Release coincident with the row-completing accept (`linesAvail` = 2):**
   - `linesAvail` stays 2; `wrLine` and `rdBase` each advance by 1.
4. **Release while `linesAvail` = 0:**
   - No change to `rdBase` or `linesAvail`.
5. **End of frame:**
   - After 48 accepts the state is DRAIN and `inReady` = 0.
   - Releasing the remaining lines gives a `frameDone` pulse of exactly 1 cycle, and a new `frameStart` restarts with `wrRow` = 0.
6. **`rst` asserted mid-row (`wrCol` = 5):**
   - All outputs return to reset values asynchronously.
   - `inValid` is ignored until `frameStart`.
